// File: rtl/snoop_fifo_pkg.sv
// Shared definitions for the snoopable FIFO and its read-side drain:
// default widths and the staging-occupancy encoding.
package snoop_fifo_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int KEY_W_DEF   = 22;
  localparam int CREDITS_DEF = 4;
  localparam int CRED_W_DEF  = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  // Even parity over a data word, for integrity checks on staged entries.
  function automatic logic even_parity(input logic [DATA_W_DEF-1:0] word);
    even_parity = ^word;
  endfunction

endpackage

// File: rtl/snoop_fifo_drain_credit_ctr.sv
// Saturating downstream credit counter with a sticky overflow flag.
// The count never wraps in either direction.
module drain_credit_ctr #(
  parameter int CREDITS = 4,
  parameter int CRED_W  = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              consume_i,
  input  logic              return_i,
  output logic [CRED_W-1:0] credits_o,
  output logic              err_o
);

  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(CREDITS);
  localparam logic [CRED_W-1:0] CRED_ONE = {{(CRED_W-1){1'b0}}, 1'b1};

  logic [CRED_W-1:0] cnt_q, cnt_d;
  logic              err_q, err_d;

  // Next credit count: a simultaneous consume and return cancel out.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (consume_i && !return_i) begin
      if (cnt_q != {CRED_W{1'b0}}) begin
        cnt_d = cnt_q - CRED_ONE;
      end else begin
        cnt_d = cnt_q;
      end
    end else if (return_i && !consume_i) begin
      if (cnt_q == CRED_MAX) begin
        err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CRED_ONE;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Credit and error registers; the error flag is cleared only by reset.
  always_ff @(posedge clk) begin
    if (rstn) begin
      cnt_q <= CRED_MAX;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign credits_o = cnt_q;
  assign err_o     = err_q;

endmodule

// File: rtl/snoop_fifo_drain.sv
// Read-side drain for the snoopable FIFO: 2-entry in-order staging buffer,
// credit-gated downstream port, and a snoop compare over staged entries.
module snoop_fifo_drain
  import snoop_fifo_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int KEY_W   = KEY_W_DEF,
  parameter int CREDITS = CREDITS_DEF,
  parameter int CRED_W  = CRED_W_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              fifo_rd_valid,
  input  logic [DATA_W-1:0] fifo_rd_data,
  output logic              fifo_rd_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  input  logic              credit_return,
  input  logic              flush,
  input  logic [KEY_W-1:0]  snoop_data,
  output logic              snoop_match,
  output logic [CRED_W-1:0] credits_avail,
  output logic              credit_err
);

  occ_e              state_q, state_d;
  logic [1:0]        vld_q, vld_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] tail_q, tail_d;
  logic              pop_s;
  logic              xfer_s;

  assign fifo_rd_ready = (state_q != TWO) && !flush;
  assign out_valid     = (state_q != EMPTY) && (credits_avail != {CRED_W{1'b0}}) && !flush;
  assign out_data      = out_valid ? head_q : {DATA_W{1'b0}};
  assign pop_s         = fifo_rd_valid && fifo_rd_ready;
  assign xfer_s        = out_valid && out_ready;

  // Slot 0 is always the oldest entry; a pop during a transfer from ONE refills slot 0.
  assign snoop_match = (vld_q[0] && (head_q[KEY_W-1:0] == snoop_data)) ||
                       (vld_q[1] && (tail_q[KEY_W-1:0] == snoop_data));

  // Occupancy and buffer next-state from pop, transfer and flush.
  always_comb begin
    state_d = state_q;
    vld_d   = vld_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush) begin
      state_d = EMPTY;
      vld_d   = 2'b00;
    end else begin
      case (state_q)
        EMPTY: begin
          if (pop_s) begin
            head_d  = fifo_rd_data;
            vld_d   = 2'b01;
            state_d = ONE;
          end else begin
            state_d = EMPTY;
          end
        end
        ONE: begin
          if (pop_s && xfer_s) begin
            head_d = fifo_rd_data;
          end else if (pop_s) begin
            tail_d  = fifo_rd_data;
            vld_d   = 2'b11;
            state_d = TWO;
          end else if (xfer_s) begin
            vld_d   = 2'b00;
            state_d = EMPTY;
          end else begin
            state_d = ONE;
          end
        end
        TWO: begin
          if (xfer_s) begin
            head_d  = tail_q;
            vld_d   = 2'b01;
            state_d = ONE;
          end else begin
            state_d = TWO;
          end
        end
        default: begin
          state_d = EMPTY;
          vld_d   = 2'b00;
        end
      endcase
    end
  end

  // Staging buffer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q <= EMPTY;
      vld_q   <= 2'b00;
      head_q  <= {DATA_W{1'b0}};
      tail_q  <= {DATA_W{1'b0}};
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  drain_credit_ctr #(
    .CREDITS (CREDITS),
    .CRED_W  (CRED_W)
  ) u_credit_ctr (
    .clk       (clk),
    .rstn      (rstn),
    .consume_i (xfer_s),
    .return_i  (credit_return),
    .credits_o (credits_avail),
    .err_o     (credit_err)
  );

endmodule
